// File: rtl/ml_inference_scheduler_if.sv
// Request, engine and result signals of the inference scheduler.
// The scheduler connects through the slave modport; the requesting side
// (feature extractors, engine, alert logic) uses the master view.
interface ml_inference_scheduler_if #(
   parameter int NUM_CH = 4
);
   localparam int CW = 3;

   logic [NUM_CH-1:0]     req_valid;
   logic [NUM_CH*128-1:0] req_features;
   logic [NUM_CH-1:0]     req_ready;

   logic [127:0]          eng_features;
   logic                  eng_feature_valid;
   logic                  eng_ml_valid;
   logic [2:0]            eng_ml_class;
   logic [7:0]            eng_ml_confidence;

   logic                  res_valid;
   logic [CW-1:0]         res_channel;
   logic [2:0]            res_class;
   logic [7:0]            res_confidence;
   logic                  res_alert;

   modport slave (
      input  req_valid, req_features, eng_ml_valid, eng_ml_class, eng_ml_confidence,
      output req_ready, eng_features, eng_feature_valid,
             res_valid, res_channel, res_class, res_confidence, res_alert
   );

   modport master (
      output req_valid, req_features, eng_ml_valid, eng_ml_class, eng_ml_confidence,
      input  req_ready, eng_features, eng_feature_valid,
             res_valid, res_channel, res_class, res_confidence, res_alert
   );
endinterface

// File: rtl/ml_inference_scheduler.sv
// Round-robin scheduler sharing one fixed-latency in-order inference engine
// between NUM_CH requesters. Each issue is tagged with its channel in a small
// FIFO; results pop the head tag and are returned to the owning channel.
module ml_inference_scheduler #(
   parameter int NUM_CH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [7:0]           cfg_min_conf,
   ml_inference_scheduler_if.slave bus,
   output logic [NUM_CH-1:0]    ch_busy,
   output logic                 idle,
   output logic                 err_orphan,
   output logic [15:0]          stat_issued
);
   localparam int CW    = 3;
   localparam int DEPTH = 8;

   logic [CW-1:0]     last_grant;
   logic [CW-1:0]     tag_mem [DEPTH];
   logic [2:0]        wr_ptr;
   logic [2:0]        rd_ptr;
   logic [3:0]        tag_count;
   logic              tag_full;
   logic              tag_empty;
   logic [CW-1:0]     head;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [CW-1:0]     grant_idx;
   logic              found;
   logic              xfer;
   logic              pop;
   logic              orphan;
   logic [127:0]      sel_features;

   assign tag_full  = (tag_count == 4'd8);
   assign tag_empty = (tag_count == 4'd0);
   assign head      = tag_mem[rd_ptr];
   assign pop       = bus.eng_ml_valid & ~tag_empty;
   assign orphan    = bus.eng_ml_valid & tag_empty;
   assign idle      = tag_empty;

   // reset gating keeps req_ready low during the reset cycle itself
   assign eligible  = bus.req_valid & ~ch_busy & {NUM_CH{enable & ~tag_full & ~rst}};

   // round-robin pick: channels above last_grant first, then wrap to the bottom
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && eligible[i] && (CW'(i) > last_grant)) begin
            grant[i]  = 1'b1;
            grant_idx = CW'(i);
            found     = 1'b1;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && eligible[i] && (CW'(i) <= last_grant)) begin
            grant[i]  = 1'b1;
            grant_idx = CW'(i);
            found     = 1'b1;
         end
      end
   end

   assign bus.req_ready = grant;
   assign xfer          = |grant;

   // feature vector of the granted channel
   always_comb begin
      sel_features = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) sel_features = bus.req_features[i*128 +: 128];
      end
   end

   // issue stage: registered engine strobe, arbitration pointer and issue counter
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.eng_feature_valid <= 1'b0;
         bus.eng_features      <= '0;
         last_grant            <= CW'(NUM_CH - 1);
         stat_issued           <= 16'd0;
      end else begin
         bus.eng_feature_valid <= xfer;
         if (xfer) begin
            bus.eng_features <= sel_features;
            last_grant       <= grant_idx;
            stat_issued      <= stat_issued + 16'd1;
         end
      end
   end

   // tag storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (xfer) tag_mem[wr_ptr] <= grant_idx;
   end

   // tag FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= 3'd0;
         rd_ptr    <= 3'd0;
         tag_count <= 4'd0;
      end else begin
         if (xfer) wr_ptr <= wr_ptr + 3'd1;
         if (pop)  rd_ptr <= rd_ptr + 3'd1;
         case ({xfer, pop})
            2'b10:   tag_count <= tag_count + 4'd1;
            2'b01:   tag_count <= tag_count - 4'd1;
            default: tag_count <= tag_count;
         endcase
      end
   end

   // retire stage: return result to the head-of-FIFO owner, flag orphans
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.res_valid      <= 1'b0;
         bus.res_channel    <= '0;
         bus.res_class      <= 3'd0;
         bus.res_confidence <= 8'd0;
         bus.res_alert      <= 1'b0;
         err_orphan         <= 1'b0;
      end else begin
         bus.res_valid <= pop;
         if (pop) begin
            bus.res_channel    <= head;
            bus.res_class      <= bus.eng_ml_class;
            bus.res_confidence <= bus.eng_ml_confidence;
            bus.res_alert      <= (bus.eng_ml_class != 3'd0) &&
                                  (bus.eng_ml_confidence >= cfg_min_conf);
         end
         if (orphan) err_orphan <= 1'b1;
      end
   end

   // busy spans issue through the result pulse; a new grant wins over the clear
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_busy <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i])
               ch_busy[i] <= 1'b1;
            else if (bus.res_valid && (bus.res_channel == CW'(i)))
               ch_busy[i] <= 1'b0;
         end
      end
   end
endmodule
